// File: rtl/seq_magnitude_comparator_if.sv
// seq_magnitude_comparator_if: start/busy/done bus carrying the operands and the gt/eq/lt result
interface seq_magnitude_comparator_if #(
    parameter int WIDTH = 16
);
    logic start;
    logic signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic busy;
    logic done;
    logic gt;
    logic eq;
    logic lt;
    modport master(output start, signed_mode, a, b, input busy, done, gt, eq, lt);
    modport slave(input start, signed_mode, a, b, output busy, done, gt, eq, lt);
endinterface

// File: rtl/seq_magnitude_comparator.sv
// seq_magnitude_comparator: iterative MSB-first slice-serial magnitude compare, unsigned or two's complement
module seq_magnitude_comparator #(
    parameter int WIDTH = 16,
    parameter int SLICE = 2,
    parameter bit EARLY_EXIT = 1
) (
    input logic clk,
    input logic reset,
    seq_magnitude_comparator_if.slave bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;
    typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;
    state_t state;
    logic [WIDTH-1:0] a_q, b_q, flip;
    logic [IW-1:0] idx;
    logic [SLICE-1:0] sa, sb;
    logic decided;
    // Flipping both sign bits at latch time turns a signed compare into an unsigned one;
    // the sign bit only lives in the top slice, so lower slices are untouched.
    assign flip = WIDTH'(bus.signed_mode) << (WIDTH - 1);
    assign sa = a_q[idx*SLICE +: SLICE];
    assign sb = b_q[idx*SLICE +: SLICE];
    assign decided = bus.gt | bus.lt;
    // Handshake FSM: latch on start, walk slices MSB first, keep only the first difference
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.gt <= 1'b0;
            bus.eq <= 1'b0;
            bus.lt <= 1'b0;
            idx <= '0;
            a_q <= '0;
            b_q <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_q <= bus.a ^ flip;
                        b_q <= bus.b ^ flip;
                        idx <= IW'(NSLICE - 1);
                        bus.gt <= 1'b0;
                        bus.eq <= 1'b0;
                        bus.lt <= 1'b0;
                        bus.busy <= 1'b1;
                        state <= COMPARE;
                    end else begin
                        state <= IDLE;
                    end
                end
                COMPARE: begin
                    if (sa != sb && !decided) begin
                        bus.gt <= sa > sb;
                        bus.lt <= sa < sb;
                    end
                    if ((EARLY_EXIT && sa != sb) || idx == '0) begin
                        bus.eq <= !decided && sa == sb;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// tb_seq_magnitude_comparator: three DUT variants (early exit, fixed latency, single slice) against a whole-word model
module tb_seq_magnitude_comparator;
    localparam logic [2:0] EE = 3'b101;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start, sm;
    logic [15:0] a, b;
    logic [2:0] busy_v, done_v, gt_v, eq_v, lt_v;
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int dcyc [3];
    logic [2:0] m_busy, m_done, m_gt, m_eq, m_lt, p_gt, p_eq, p_lt;
    int m_cnt [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        seq_magnitude_comparator_if #(.WIDTH(16)) bus();
        seq_magnitude_comparator #(.WIDTH(16), .SLICE(g == 2 ? 16 : 2), .EARLY_EXIT(EE[g])) dut (
            .clk(clk),
            .reset(reset),
            .bus(bus.slave)
        );
        assign bus.start = start;
        assign bus.signed_mode = sm;
        assign bus.a = a;
        assign bus.b = b;
        assign busy_v[g] = bus.busy;
        assign done_v[g] = bus.done;
        assign gt_v[g] = bus.gt;
        assign eq_v[g] = bus.eq;
        assign lt_v[g] = bus.lt;
    end

    task automatic chk(string nm, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int nsl(int i);
        return i == 2 ? 1 : 8;
    endfunction

    function automatic int slw(int i);
        return i == 2 ? 16 : 2;
    endfunction

    // slices examined = slices from the top down to the one holding the highest differing bit
    function automatic int lat_k(int i, logic [15:0] x, logic [15:0] y);
        logic [15:0] d;
        int p;
        d = x ^ y;
        p = 0;
        if (EE[i] == 1'b0 || d == 16'h0) return nsl(i);
        for (int j = 0; j < 16; j++) if (d[j]) p = j;
        return nsl(i) - p / slw(i);
    endfunction

    // reference: whole-word compare, busy for k cycles, then a one-cycle done with the result
    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                m_busy[i] <= 1'b0;
                m_done[i] <= 1'b0;
                m_cnt[i] <= 0;
                m_gt[i] <= 1'b0;
                m_eq[i] <= 1'b0;
                m_lt[i] <= 1'b0;
            end else if (m_busy[i]) begin
                if (m_cnt[i] == 1) begin
                    m_busy[i] <= 1'b0;
                    m_done[i] <= 1'b1;
                    m_gt[i] <= p_gt[i];
                    m_eq[i] <= p_eq[i];
                    m_lt[i] <= p_lt[i];
                end else begin
                    m_cnt[i] <= m_cnt[i] - 1;
                end
            end else begin
                m_done[i] <= 1'b0;
                if (start) begin
                    m_busy[i] <= 1'b1;
                    m_cnt[i] <= lat_k(i, a, b);
                    p_eq[i] <= a == b;
                    p_lt[i] <= sm ? ($signed(a) < $signed(b)) : (a < b);
                    p_gt[i] <= sm ? ($signed(a) > $signed(b)) : (a > b);
                    m_gt[i] <= 1'b0;
                    m_eq[i] <= 1'b0;
                    m_lt[i] <= 1'b0;
                end
            end
        end
    end

    // every cycle: handshake always, result whenever no compare is in flight
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d_busy", i), busy_v[i], m_busy[i]);
            chk($sformatf("u%0d_done", i), done_v[i], m_done[i]);
            if (!m_busy[i]) chk($sformatf("u%0d_gel", i), {gt_v[i], eq_v[i], lt_v[i]}, {m_gt[i], m_eq[i], m_lt[i]});
            if (done_v[i]) dcyc[i] = cyc;
        end
    end

    task automatic go(input logic [15:0] x, input logic [15:0] y, input logic s, output int c0);
        a = x;
        b = y;
        sm = s;
        start = 1'b1;
        c0 = cyc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic settle();
        for (int n = 0; n < 60 && busy_v != 3'b000; n++) @(negedge clk);
        chk("settle", busy_v, 0);
        @(negedge clk);
    endtask

    task automatic wait_done0();
        for (int n = 0; n < 30 && !done_v[0]; n++) @(negedge clk);
        chk("wait_done0", done_v[0], 1);
    endtask

    task automatic lit(string nm, int i, int c0, int lat, logic [2:0] res);
        chk({nm, "_lat"}, dcyc[i] - c0, lat);
        chk({nm, "_gel"}, {gt_v[i], eq_v[i], lt_v[i]}, res);
    endtask

    initial begin
        int c0, c1;
        start = 1'b0;
        sm = 1'b0;
        a = '0;
        b = '0;
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {busy_v, done_v, gt_v, eq_v, lt_v}, 0);
        reset = 1'b0;
        go(16'h8000, 16'h7FFF, 1'b0, c0);
        settle();
        lit("t1_u0", 0, c0, 2, 3'b100);
        lit("t1_u1", 1, c0, 9, 3'b100);
        lit("t1_u2", 2, c0, 2, 3'b100);
        go(16'h1234, 16'h1234, 1'b0, c0);
        wait_done0();
        chk("t2_lat", cyc - c0, 9);
        chk("t2_eq", {gt_v[0], eq_v[0], lt_v[0]}, 3'b010);
        go(16'h1233, 16'h1234, 1'b0, c1);
        settle();
        lit("t2b_u0", 0, c1, 8, 3'b001);
        lit("t2b_u1", 1, c1, 9, 3'b001);
        lit("t2b_u2", 2, c1, 2, 3'b001);
        go(16'hFFFF, 16'h0001, 1'b1, c0);
        settle();
        lit("t3s_u0", 0, c0, 2, 3'b001);
        lit("t3s_u1", 1, c0, 9, 3'b001);
        lit("t3s_u2", 2, c0, 2, 3'b001);
        go(16'hFFFF, 16'h0001, 1'b0, c0);
        settle();
        lit("t3u_u0", 0, c0, 2, 3'b100);
        go(16'h4000, 16'h3FFF, 1'b0, c0);
        settle();
        lit("t4_u1", 1, c0, 9, 3'b100);
        lit("t4_u0", 0, c0, 2, 3'b100);
        go(16'h1234, 16'h1234, 1'b0, c0);
        repeat (2) @(negedge clk);
        go(16'hFFFF, 16'h0000, 1'b0, c1);
        wait_done0();
        @(negedge clk);
        chk("t5_pulse", done_v[0], 0);
        settle();
        lit("t5_u0", 0, c0, 9, 3'b010);
        lit("t5_u1", 1, c0, 9, 3'b010);
        go(16'h5555, 16'h5555, 1'b0, c0);
        for (int n = 0; n < 10 && cyc < c0 + 4; n++) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("t6_reset", {busy_v, done_v, gt_v, eq_v, lt_v}, 0);
        reset = 1'b0;
        go(16'h8000, 16'h7FFF, 1'b0, c0);
        settle();
        lit("t6_u0", 0, c0, 2, 3'b100);
        repeat (400) begin
            @(posedge clk);
            #1;
            start = ($urandom % 3) == 0;
            sm = 1'($urandom);
            a = 16'($urandom);
            case ($urandom % 3)
                0: b = a;
                1: b = a ^ (16'h1 << ($urandom % 16));
                default: b = 16'($urandom);
            endcase
        end
        #1 start = 1'b0;
        settle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
